// File: rtl/uart_tx_arb_pkg.sv
// Shared types, constants and the round-robin selection helper for uart_tx_arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } arb_state_t;

    localparam int QUIET_CYCLES = 3;
    localparam int MAX_REQ      = 8;

    // First set bit of valid, searching upward from ptr and wrapping at nreq.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 nreq);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % nreq;
            if (!found && (i < nreq) && valid[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_sync_2ff.sv
// Two-flop synchronizer with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmit FIFO among NREQ requesters,
// with optional header byte and tx_begin start/stop control.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int DATA_W      = 8,
    parameter int HDR_EN      = 1,
    parameter int START_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_wen,
    output logic [DATA_W-1:0]        tx_wr_data,
    output logic                     tx_begin,
    input  logic                     tx_full,
    input  logic                     tx_empty,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(START_LEVEL + 1);

    arb_state_t     state_q,     state_d;
    logic [GW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [GW-1:0]  grant_q,     grant_d;
    logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
    logic [1:0]     quiet_cnt_q, quiet_cnt_d;
    logic           tx_begin_q,  tx_begin_d;
    logic           wr_last;
    logic           empty_sync;

    sync_2ff #(.RESET_VAL(1'b1)) u_empty_sync (
        .clk (clk),
        .rst (rst),
        .d   (tx_empty),
        .q   (empty_sync)
    );

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        tx_begin_d  = tx_begin_q;
        tx_wen      = 1'b0;
        tx_wr_data  = '0;
        req_ready   = '0;
        wr_last     = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = GW'(rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr_q), NREQ));
                    state_d = (HDR_EN != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                tx_wen     = !tx_full;
                tx_wr_data = DATA_W'(grant_q);
                if (!tx_full) state_d = DATA;
            end
            DATA: begin
                req_ready[grant_q] = !tx_full;
                tx_wen             = req_valid[grant_q] && !tx_full;
                tx_wr_data         = req_data[int'(grant_q)*DATA_W +: DATA_W];
                wr_last            = tx_wen && req_last[grant_q];
                if (wr_last) begin
                    rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Header and data writes both count toward the start threshold.
        if (tx_wen) begin
            quiet_cnt_d = '0;
            if (burst_cnt_q < BW'(START_LEVEL)) burst_cnt_d = burst_cnt_q + BW'(1);
            if ((burst_cnt_d == BW'(START_LEVEL)) || wr_last) tx_begin_d = 1'b1;
        end else if (quiet_cnt_q < 2'(QUIET_CYCLES)) begin
            quiet_cnt_d = quiet_cnt_q + 2'd1;
        end

        // Quiet window covers synchronizer plus FIFO flag latency before trusting empty.
        if ((state_q == IDLE) && (quiet_cnt_q >= 2'(QUIET_CYCLES)) && empty_sync) begin
            tx_begin_d  = 1'b0;
            burst_cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            quiet_cnt_q <= 2'(QUIET_CYCLES);
            tx_begin_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            tx_begin_q  <= tx_begin_d;
        end
    end

    assign tx_begin = tx_begin_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (header and no-header instances).
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        tx_full;
    logic        tx_empty;

    logic [3:0]  ready_h,  ready_n;
    logic        wen_h,    wen_n;
    logic [7:0]  wdata_h,  wdata_n;
    logic        begin_h,  begin_n;
    logic        busy_h,   busy_n;
    logic [1:0]  grant_h,  grant_n;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .HDR_EN(1), .START_LEVEL(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (ready_h),
        .tx_wen     (wen_h),
        .tx_wr_data (wdata_h),
        .tx_begin   (begin_h),
        .tx_full    (tx_full),
        .tx_empty   (tx_empty),
        .busy       (busy_h),
        .grant_id   (grant_h)
    );

    uart_tx_arbiter #(.NREQ(4), .DATA_W(8), .HDR_EN(0), .START_LEVEL(4)) dut_nh (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (ready_n),
        .tx_wen     (wen_n),
        .tx_wr_data (wdata_n),
        .tx_begin   (begin_n),
        .tx_full    (tx_full),
        .tx_empty   (tx_empty),
        .busy       (busy_n),
        .grant_id   (grant_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input int idx, input logic [7:0] v);
        req_data[idx*8 +: 8] = v;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int g;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_full   = 1'b0;
        tx_empty  = 1'b1;
        #3;
        check("rst_wen",   wen_h,   0);
        check("rst_ready", ready_h, 0);
        check("rst_wdata", wdata_h, 0);
        check("rst_begin", begin_h, 0);
        check("rst_busy",  busy_h,  0);
        check("rst_grant", grant_h, 0);
        tick();
        rst = 1'b0;

        // Single requester 0: 00, A1, A2, A3 then drain.
        req_valid = 4'b0001;
        set_byte(0, 8'hA1);
        #1;
        check("t1_idle_wen",  wen_h,  0);
        check("t1_idle_busy", busy_h, 0);
        tick(); #1;
        check("t1_hdr_wen",   wen_h,   1);
        check("t1_hdr_data",  wdata_h, 8'h00);
        check("t1_hdr_ready", ready_h, 4'b0000);
        check("t1_hdr_busy",  busy_h,  1);
        tick(); tx_empty = 1'b0; #1;
        check("t1_a1_wen",   wen_h,   1);
        check("t1_a1_data",  wdata_h, 8'hA1);
        check("t1_a1_ready", ready_h, 4'b0001);
        tick(); set_byte(0, 8'hA2); #1;
        check("t1_a2_data", wdata_h, 8'hA2);
        tick(); set_byte(0, 8'hA3); req_last = 4'b0001; #1;
        check("t1_a3_data",  wdata_h, 8'hA3);
        check("t1_a3_wen",   wen_h,   1);
        check("t1_pre_begin", begin_h, 0);
        tick(); req_valid = '0; req_last = '0; #1;
        check("t1_begin_up", begin_h, 1);
        check("t1_idle_after", busy_h, 0);
        check("t1_grant", grant_h, 0);
        check("t1_no_wen", wen_h, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t1_begin_quiet", begin_h, 1);
        end
        tx_empty = 1'b1;
        tick(); #1;
        check("t1_begin_sync1", begin_h, 1);
        tick(); #1;
        check("t1_begin_sync2", begin_h, 1);
        tick(); #1;
        check("t1_begin_fall", begin_h, 0);
        check("t1_burst_zero", dut.burst_cnt_q, 0);

        // Round-robin with all four requesters holding single-byte packets.
        tick();
        pulse_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int i = 0; i < 4; i++) set_byte(i, 8'hB0 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            g = k % 4;
            #1;
            check("rr_idle_wen",  wen_h,  0);
            check("rr_idle_busy", busy_h, 0);
            tick(); #1;
            check("rr_hdr_data",  wdata_h, 32'(g));
            check("rr_hdr_grant", grant_h, 32'(g));
            check("rr_hdr_wen",   wen_h,   1);
            tick(); #1;
            check("rr_data",  wdata_h, 32'hB0 + 32'(g));
            check("rr_ready", ready_h, 32'(1) << g);
            tick();
        end

        // Backpressure on requester 1 (rr_ptr now 1).
        req_valid = 4'b0010;
        req_last  = '0;
        set_byte(1, 8'hC1);
        #1;
        check("bp_idle_wen", wen_h, 0);
        tick(); #1;
        check("bp_hdr_data", wdata_h, 8'h01);
        tick(); #1;
        check("bp_c1_data",  wdata_h, 8'hC1);
        check("bp_c1_ready", ready_h, 4'b0010);
        tick(); set_byte(1, 8'hC2); tx_full = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("bp_stall_wen",   wen_h,   0);
            check("bp_stall_ready", ready_h, 0);
            tick();
        end
        tx_full = 1'b0; #1;
        check("bp_c2_data", wdata_h, 8'hC2);
        check("bp_c2_wen",  wen_h,   1);
        tick(); set_byte(1, 8'hC3); #1;
        check("bp_c3_data", wdata_h, 8'hC3);
        tick(); set_byte(1, 8'hC4); req_last = 4'b0010; #1;
        check("bp_c4_data", wdata_h, 8'hC4);
        check("bp_c4_wen",  wen_h,   1);
        tick(); req_valid = '0; req_last = '0; #1;
        check("bp_done_busy", busy_h, 0);

        // Reset mid-packet of requester 2 (rr_ptr now 2).
        req_valid = 4'b0100;
        set_byte(2, 8'hD1);
        tick(); #1;
        check("rm_hdr_data", wdata_h, 8'h02);
        tick(); #1;
        check("rm_d1_data", wdata_h, 8'hD1);
        tick(); set_byte(2, 8'hD2); #1;
        check("rm_d2_wen", wen_h, 1);
        rst = 1'b1; #1;
        check("rm_wen",   wen_h,   0);
        check("rm_ready", ready_h, 0);
        check("rm_wdata", wdata_h, 0);
        check("rm_begin", begin_h, 0);
        check("rm_busy",  busy_h,  0);
        check("rm_grant", grant_h, 0);
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        set_byte(2, 8'hB2);
        #1;
        check("rm_next_idle", wen_h, 0);
        tick(); #1;
        check("rm_next_grant", grant_h, 0);
        check("rm_next_hdr",   wdata_h, 8'h00);
        tick(); #1;
        check("rm_next_data", wdata_h, 8'hB0);
        tick(); req_valid = '0; req_last = '0;

        // No-header instance: requester 1 sends single byte 5A.
        pulse_reset();
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        set_byte(1, 8'h5A);
        #1;
        check("nh_idle_wen",  wen_n,  0);
        check("nh_idle_busy", busy_n, 0);
        tick(); #1;
        check("nh_wen",   wen_n,   1);
        check("nh_data",  wdata_n, 8'h5A);
        check("nh_ready", ready_n, 4'b0010);
        check("nh_begin_pre", begin_n, 0);
        tick(); req_valid = '0; req_last = '0; #1;
        check("nh_busy_after",  busy_n,  0);
        check("nh_begin_after", begin_n, 1);
        check("nh_wen_after",   wen_n,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
